// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - serial boot loader filling MIPS instruction memory from a byte stream
// Holds the core in reset until a counted, checksummed image has been written.
module mips_imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_a_rst_n,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    input  logic              i_reload,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    state_t              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          xor_q, xor_d;
    logic [31:0]         word_q, word_d;
    logic [1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;

    logic                xfer;
    logic [15:0]         count_in;
    logic [31:0]         shifted;

    assign o_rx_ready = !i_reload &&
                        (state_q == S_CNT_HI || state_q == S_CNT_LO ||
                         state_q == S_DATA   || state_q == S_CSUM);
    assign xfer       = i_rx_valid && o_rx_ready;
    assign count_in   = {cnt_hi_q, i_rx_data};
    assign shifted    = {word_q[23:0], i_rx_data};

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        word_d      = word_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_rst_n_d = cpu_rst_n_q;

        if (i_reload) begin
            state_d     = S_CNT_HI;
            idx_d       = 2'd0;
            done_d      = 1'b0;
            error_d     = 1'b0;
            cpu_rst_n_d = 1'b0;
        end else if (xfer) begin
            case (state_q)
                S_CNT_HI: begin
                    cnt_hi_d = i_rx_data;
                    xor_d    = i_rx_data;
                    state_d  = S_CNT_LO;
                end
                S_CNT_LO: begin
                    xor_d = xor_q ^ i_rx_data;
                    if (32'(count_in) > MAX_WORDS) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (count_in == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = count_in;
                        addr_d  = '0;
                        idx_d   = 2'd0;
                    end
                end
                S_DATA: begin
                    xor_d  = xor_q ^ i_rx_data;
                    word_d = shifted;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = shifted;
                        addr_d  = addr_q + 1'b1;
                        cnt_d   = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (i_rx_data == xor_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state_q     <= S_CNT_HI;
            cnt_hi_q    <= 8'd0;
            cnt_q       <= 16'd0;
            xor_q       <= 8'd0;
            word_q      <= 32'd0;
            idx_q       <= 2'd0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign o_imem_we    = we_q;
    assign o_imem_addr  = waddr_q;
    assign o_imem_wdata = wdata_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_cpu_rst_n  = cpu_rst_n_q;

endmodule
